pipe_stage_skid: RTL and testbench

//  Parametrised pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_sat_counter.sv | 37 +++
 rtl/pipe_stage_skid.sv | 177 +++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage skid register: occupancy states,
// default widths and the bit positions inside the control bundle.
package pipe_pkg;

  // Occupancy of the stage: nothing held, one beat in main, or main plus skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Default widths used when a stage instance does not override them
  localparam int PIPE_DATA_W = 16;
  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_DEST_W = 4;

  // Bit positions inside the control bundle
  localparam int CTRL_HLT      = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_PCS      = 5;
  localparam int CTRL_LOADBYTE = 6;
  localparam int CTRL_SW       = 7;

  // True when a control word would change architectural state (halt, store, register write)
  function automatic logic ctrl_has_side_effect(input logic [PIPE_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_HLT] | ctrl[CTRL_MEMWRITE] | ctrl[CTRL_REGWRITE];
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for stage performance monitoring.
// Counts one per cycle while inc is high and sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_max;

  assign at_max = &count_q;

  // Next count: step when requested unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && !at_max) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
// Sits between two CPU stages; carries data, control bundle and destination register.
// up_ready comes straight from the occupancy register, so upstream never sees a
// combinational path from dn_ready. Control reads as zero whenever no beat is held.
// Optional build macro: PIPE_STAGE_PERF_EN adds stall_cnt / bubble_cnt counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DEST_W = PIPE_DEST_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DEST_W-1:0] up_dest,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [DEST_W-1:0] dn_dest
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Reject meaningless widths at elaboration time
  if (DATA_W < 1 || CTRL_W < 1 || DEST_W < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_skid: all widths must be at least 1");
  end

  stage_state_e      state_q;
  stage_state_e      state_d;

  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DEST_W-1:0] main_dest_q;
  logic [DEST_W-1:0] main_dest_d;

  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_d;
  logic [DEST_W-1:0] skid_dest_q;
  logic [DEST_W-1:0] skid_dest_d;

  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              drain;

  // Both valid bits are encoded in the state register; up_ready is therefore registered
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);
  assign up_ready   = ~skid_valid;

  assign accept = up_valid & up_ready;
  assign drain  = main_valid & dn_ready;

  // Next occupancy and data movement; flush overrides every handshake
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_dest_d = main_dest_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_dest_d = skid_dest_q;

    if (flush) begin
      // Held and incoming beats are discarded; stale payload stays but is masked off
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = up_data;
            main_ctrl_d = up_ctrl;
            main_dest_d = up_dest;
          end
        end
        ONE: begin
          if (accept && drain) begin
            // Main leaves and is replaced in the same cycle: stays ONE at full rate
            main_data_d = up_data;
            main_ctrl_d = up_ctrl;
            main_dest_d = up_dest;
          end else if (accept) begin
            // Downstream stalled: park the new beat behind main
            state_d     = FULL;
            skid_data_d = up_data;
            skid_ctrl_d = up_ctrl;
            skid_dest_d = up_dest;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            // Older beat left; promote the skid entry so order is preserved
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            main_dest_d = skid_dest_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and payload registers, all cleared by asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_dest_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_dest_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      main_dest_q <= main_dest_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_dest_q <= skid_dest_d;
    end
  end

  // Downstream view: control gated by valid so bubbles never write, store or halt
  assign dn_valid = main_valid;
  assign dn_data  = main_data_q;
  assign dn_ctrl  = main_ctrl_q & {CTRL_W{main_valid}};
  assign dn_dest  = main_dest_q;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = main_valid & ~dn_ready;
  assign bubble_inc = ~main_valid;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a table of per-cycle vectors plus
// hand-written sequences for asynchronous reset and the optional counters.
module tb_pipe_stage_skid;

  import pipe_pkg::*;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int RW = 4;
`ifdef PIPE_STAGE_PERF_EN
  localparam int NW = 4;
`else
  localparam int NW = 16;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_data;
  logic [CW-1:0] up_ctrl;
  logic [RW-1:0] up_dest;
  logic          dn_valid;
  logic          dn_ready;
  logic [DW-1:0] dn_data;
  logic [CW-1:0] dn_ctrl;
  logic [RW-1:0] dn_dest;
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] bubble_cnt;
`endif

  pipe_stage_skid #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .DEST_W (RW),
    .CNT_W  (NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_ctrl    (up_ctrl),
    .up_dest    (up_dest),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .dn_data    (dn_data),
    .dn_ctrl    (dn_ctrl),
    .dn_dest    (dn_dest)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          uv;
    logic          dr;
    logic          fl;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [RW-1:0] dst;
    logic          ev;
    logic          eur;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic [RW-1:0] edst;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Row: inputs applied before an edge, expected outputs seen just after it
  task automatic add(input logic uv, input logic dr, input logic fl,
                     input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic ev, input logic eur,
                     input logic [DW-1:0] ed, input logic [CW-1:0] ec);
    vec_t v;
    v.uv = uv; v.dr = dr; v.fl = fl;
    v.d = d; v.c = c; v.dst = d[RW-1:0];
    v.ev = ev; v.eur = eur; v.ed = ed; v.ec = ec; v.edst = ed[RW-1:0];
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    up_valid = 1'b0;
    up_data  = '0;
    up_ctrl  = '0;
    up_dest  = '0;
    dn_ready = 1'b0;

    // Streaming: 0x0001..0x0010, each visible the cycle after acceptance
    for (int k = 1; k <= 16; k++) begin
      add(1, 1, 0, DW'(k), 8'h10, 1, 1, DW'(k), 8'h10);
    end
    add(0, 1, 0, 16'h0000, 8'h00, 0, 1, 16'h0000, 8'h00);
    // Stall fill, held output, rejected beat in FULL, in-order drain
    add(1, 0, 0, 16'hAAAA, 8'h18, 1, 1, 16'hAAAA, 8'h18);
    add(1, 0, 0, 16'hBBBB, 8'h18, 1, 0, 16'hAAAA, 8'h18);
    add(1, 0, 0, 16'hDDDD, 8'h18, 1, 0, 16'hAAAA, 8'h18);
    add(0, 1, 0, 16'h0000, 8'h00, 1, 1, 16'hBBBB, 8'h18);
    add(0, 1, 0, 16'h0000, 8'h00, 0, 1, 16'h0000, 8'h00);
    // Bubble control masking
    add(1, 1, 0, 16'h1234, 8'hFF, 1, 1, 16'h1234, 8'hFF);
    add(0, 1, 0, 16'h0000, 8'hFF, 0, 1, 16'h0000, 8'h00);
    // Flush while FULL with an incoming beat
    add(1, 0, 0, 16'h1111, 8'h10, 1, 1, 16'h1111, 8'h10);
    add(1, 0, 0, 16'h2222, 8'h10, 1, 0, 16'h1111, 8'h10);
    add(1, 0, 1, 16'hCCCC, 8'h10, 0, 1, 16'h0000, 8'h00);
    add(0, 1, 0, 16'h0000, 8'h00, 0, 1, 16'h0000, 8'h00);
    // Flush in ONE with accept and drain in the same cycle
    add(1, 1, 0, 16'h5555, 8'h10, 1, 1, 16'h5555, 8'h10);
    add(1, 1, 1, 16'h6666, 8'h10, 0, 1, 16'h0000, 8'h00);
    add(0, 0, 0, 16'h0000, 8'h00, 0, 1, 16'h0000, 8'h00);
    // ONE: replace-in-place, hold, then drain to EMPTY
    add(1, 0, 0, 16'h7001, 8'h10, 1, 1, 16'h7001, 8'h10);
    add(1, 1, 0, 16'h7002, 8'h10, 1, 1, 16'h7002, 8'h10);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h7002, 8'h10);
    add(0, 1, 0, 16'h0000, 8'h00, 0, 1, 16'h0000, 8'h00);
    // FULL drain with upstream still offering: offered beat retried and kept in order
    add(1, 0, 0, 16'h8001, 8'h08, 1, 1, 16'h8001, 8'h08);
    add(1, 0, 0, 16'h8002, 8'h08, 1, 0, 16'h8001, 8'h08);
    add(1, 1, 0, 16'h8003, 8'h08, 1, 1, 16'h8002, 8'h08);
    add(1, 1, 0, 16'h8003, 8'h08, 1, 1, 16'h8003, 8'h08);
    add(0, 1, 0, 16'h0000, 8'h00, 0, 1, 16'h0000, 8'h00);

    // Reset state, observed while rst is held
    tick();
    check("rst_dn_valid", {31'd0, dn_valid}, 32'd0);
    check("rst_up_ready", {31'd0, up_ready}, 32'd1);
    check("rst_dn_data", {16'd0, dn_data}, 32'd0);
    check("rst_dn_ctrl", {24'd0, dn_ctrl}, 32'd0);
    check("rst_dn_dest", {28'd0, dn_dest}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table run
    foreach (vecs[i]) begin
      up_valid = vecs[i].uv;
      dn_ready = vecs[i].dr;
      flush    = vecs[i].fl;
      up_data  = vecs[i].d;
      up_ctrl  = vecs[i].c;
      up_dest  = vecs[i].dst;
      tick();
      check($sformatf("v%0d_dn_valid", i), {31'd0, dn_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_up_ready", i), {31'd0, up_ready}, {31'd0, vecs[i].eur});
      check($sformatf("v%0d_dn_ctrl", i), {24'd0, dn_ctrl}, {24'd0, vecs[i].ec});
      if (vecs[i].ev) begin
        check($sformatf("v%0d_dn_data", i), {16'd0, dn_data}, {16'd0, vecs[i].ed});
        check($sformatf("v%0d_dn_dest", i), {28'd0, dn_dest}, {28'd0, vecs[i].edst});
      end else begin
        check($sformatf("v%0d_bubble_inert", i),
              {31'd0, ctrl_has_side_effect(dn_ctrl)}, 32'd0);
      end
    end
    flush = 1'b0;

    // Asynchronous reset between edges while ONE
    up_valid = 1'b1; up_data = 16'h7777; up_ctrl = 8'h10; up_dest = 4'h7; dn_ready = 1'b0;
    tick();
    check("ar_pre_dn_valid", {31'd0, dn_valid}, 32'd1);
    check("ar_pre_dn_data", {16'd0, dn_data}, 32'h7777);
    up_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("ar_dn_valid", {31'd0, dn_valid}, 32'd0);
    check("ar_dn_data", {16'd0, dn_data}, 32'd0);
    check("ar_dn_ctrl", {24'd0, dn_ctrl}, 32'd0);
    check("ar_up_ready", {31'd0, up_ready}, 32'd1);
    tick();
    check("ar_hold_dn_valid", {31'd0, dn_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("ar_after_dn_valid", {31'd0, dn_valid}, 32'd0);
    check("ar_after_up_ready", {31'd0, up_ready}, 32'd1);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturates at 15 and survives flush; bubble counter saturates too
    up_valid = 1'b1; up_data = 16'h9999; up_ctrl = 8'h10; up_dest = 4'h9; dn_ready = 1'b0;
    tick();
    up_valid = 1'b0;
    repeat (20) tick();
    check("perf_stall_sat", {28'd0, stall_cnt}, 32'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf_stall_after_flush", {28'd0, stall_cnt}, 32'd15);
    repeat (20) tick();
    check("perf_bubble_sat", {28'd0, bubble_cnt}, 32'd15);
    check("perf_stall_idle", {28'd0, stall_cnt}, 32'd15);
    rst = 1'b1;
    #1;
    check("perf_stall_rst", {28'd0, stall_cnt}, 32'd0);
    check("perf_bubble_rst", {28'd0, bubble_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
